// File: rtl/video_pkg.sv
// Shared video definitions: scanline mode encoding, counter width default,
// RGB channel width, and the per-channel dimming arithmetic.
package video_pkg;

  localparam int COUNT_W_DEF = 10;
  localparam int CH_W        = 8;
  localparam int RGB_W       = 3 * CH_W;

  typedef enum logic [1:0] {
    SL_OFF   = 2'd0,
    SL_DIM25 = 2'd1,
    SL_DIM50 = 2'd2,
    SL_DIM75 = 2'd3
  } sl_mode_e;

  // Dim one channel by the selected amount; shifts only, no multipliers.
  function automatic logic [CH_W-1:0] dim_ch(input logic [CH_W-1:0] c,
                                             input sl_mode_e m);
    case (m)
      SL_DIM25: return c - (c >> 2);
      SL_DIM50: return c >> 1;
      SL_DIM75: return c >> 2;
      default:  return c;
    endcase
  endfunction

endpackage

// File: rtl/scanline_dim.sv
// One colour channel of the scanline dimmer, with a single register stage.
//   clk_vid, reset : video clock, synchronous active-high reset
//   en_i           : dim this pixel (active video on an odd line)
//   mode_i         : active scanline mode
//   ch_i / ch_o    : channel in / registered channel out
module scanline_dim
  import video_pkg::*;
(
  input  logic            clk_vid,
  input  logic            reset,
  input  logic            en_i,
  input  logic [1:0]      mode_i,
  input  logic [CH_W-1:0] ch_i,
  output logic [CH_W-1:0] ch_o
);

  logic [CH_W-1:0] ch_d, ch_q;

  always_comb begin
    ch_d = ch_i;
    if (en_i) ch_d = dim_ch(ch_i, sl_mode_e'(mode_i));
  end

  always_ff @(posedge clk_vid) begin
    if (reset) ch_q <= '0;
    else       ch_q <= ch_d;
  end

  assign ch_o = ch_q;

endmodule

// File: rtl/video_out_stage.sv
// Video output stage: scanline dimming with a fixed two-cycle pipeline, plus
// per-frame width/height statistics and a line-width mismatch flag.
//   clk_vid, reset             : video clock, synchronous active-high reset
//   vsync_in/hsync_in/de_in    : frame start, line start, data enable
//   rgb_in                     : {R,G,B}; slot word on the cycle after de falls
//   scanline_mode              : 0 off, 1/2/3 dim 25/50/75 % (taken at vsync)
//   vsync_out/hsync_out/de_out : syncs delayed by PIPE_LAT
//   rgb_out                    : processed pixels delayed by PIPE_LAT
//   frame_width/frame_height   : previous frame statistics
//   stats_valid                : one-cycle pulse when the statistics update
//   width_mismatch             : previous frame had lines of unequal width
module video_out_stage
  import video_pkg::*;
#(
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int PIPE_LAT = 2            // the rgb path is built for 2 only
) (
  input  logic               clk_vid,
  input  logic               reset,
  input  logic               vsync_in,
  input  logic               hsync_in,
  input  logic               de_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [1:0]         scanline_mode,
  output logic               vsync_out,
  output logic               hsync_out,
  output logic               de_out,
  output logic [RGB_W-1:0]   rgb_out,
  output logic [COUNT_W-1:0] frame_width,
  output logic [COUNT_W-1:0] frame_height,
  output logic               stats_valid,
  output logic               width_mismatch
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // ---------------- pixel path ----------------
  logic [PIPE_LAT-1:0][2:0] sync_q;   // {vsync, hsync, de} per stage
  logic [1:0]               mode_q;
  logic                     line_odd_q;  // LSB of the line index
  logic [RGB_W-1:0]         rgb1, rgb2_q;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    scanline_dim u_dim (
      .clk_vid (clk_vid),
      .reset   (reset),
      .en_i    (de_in & line_odd_q),
      .mode_i  (mode_q),
      .ch_i    (rgb_in[c*CH_W +: CH_W]),
      .ch_o    (rgb1[c*CH_W +: CH_W])
    );
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      sync_q <= '0;
      rgb2_q <= '0;
    end else begin
      sync_q <= {sync_q[PIPE_LAT-2:0], {vsync_in, hsync_in, de_in}};
      rgb2_q <= rgb1;
    end
  end

  assign {vsync_out, hsync_out, de_out} = sync_q[PIPE_LAT-1];
  assign rgb_out = rgb2_q;

  // ---------------- statistics ----------------
  logic               de_prev_q, fall;
  logic [COUNT_W-1:0] wcnt_q, wcnt_d;
  logic [COUNT_W-1:0] refw_q, refw_d;
  logic [COUNT_W-1:0] lines_q, lines_d;
  logic               mism_q, mism_d;
  logic [COUNT_W-1:0] fw_q, fh_q;
  logic               wm_q, sv_q;

  assign fall = de_prev_q & ~de_in;

  // Frame-level values including a line that ends this cycle, so a vsync
  // coinciding with the fall latches the completed line too.
  always_comb begin
    refw_d  = refw_q;
    lines_d = lines_q;
    mism_d  = mism_q;
    wcnt_d  = wcnt_q;
    if (fall) begin
      if (lines_q == '0)        refw_d = wcnt_q;  // first line sets reference
      else if (wcnt_q != refw_q) mism_d = 1'b1;
      if (lines_q != CNT_MAX)   lines_d = lines_q + 1'b1;
      wcnt_d = '0;
    end else if (de_in && wcnt_q != CNT_MAX) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      de_prev_q  <= 1'b0;
      mode_q     <= '0;
      line_odd_q <= 1'b0;
      wcnt_q     <= '0;
      refw_q     <= '0;
      lines_q    <= '0;
      mism_q     <= 1'b0;
      fw_q       <= '0;
      fh_q       <= '0;
      wm_q       <= 1'b0;
      sv_q       <= 1'b0;
    end else begin
      de_prev_q <= de_in;
      sv_q      <= vsync_in;
      if (vsync_in) begin
        mode_q     <= scanline_mode;
        fw_q       <= refw_d;
        fh_q       <= lines_d;
        wm_q       <= mism_d;
        // A line still in progress is dropped: its width restarts at 0.
        wcnt_q     <= '0;
        refw_q     <= '0;
        lines_q    <= '0;
        mism_q     <= 1'b0;
        line_odd_q <= 1'b0;
      end else begin
        wcnt_q     <= wcnt_d;
        refw_q     <= refw_d;
        lines_q    <= lines_d;
        mism_q     <= mism_d;
        line_odd_q <= line_odd_q ^ fall;
      end
    end
  end

  assign frame_width    = fw_q;
  assign frame_height   = fh_q;
  assign width_mismatch = wm_q;
  assign stats_valid    = sv_q;

endmodule

// File: tb/tb_video_out_stage.sv
module tb_video_out_stage;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_vid = 1'b0;
  logic          reset = 1'b1, vsync_in = 1'b0, hsync_in = 1'b0, de_in = 1'b0;
  logic [23:0]   rgb_in = '0;
  logic [1:0]    scanline_mode = '0;
  logic          vsync_out, hsync_out, de_out, stats_valid, width_mismatch;
  logic [23:0]   rgb_out;
  logic [CW-1:0] frame_width, frame_height;

  video_out_stage #(.COUNT_W(CW), .PIPE_LAT(2)) dut (
    .clk_vid(clk_vid), .reset(reset), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .de_in(de_in), .rgb_in(rgb_in), .scanline_mode(scanline_mode),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out), .rgb_out(rgb_out),
    .frame_width(frame_width), .frame_height(frame_height),
    .stats_valid(stats_valid), .width_mismatch(width_mismatch));

  always #5 clk_vid = ~clk_vid;

  typedef struct { int due; logic v, h, de; logic [23:0] rgb; } pix_t;
  typedef struct { int due; logic sv; int fw, fh; logic wm; } st_t;
  pix_t pix_q[$];
  st_t  st_q[$];

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  always @(posedge clk_vid) cyc <= cyc + 1;

  // Reference model state (frame-level view of the rules)
  logic [1:0] mode_drv = 0;  // value driven on scanline_mode
  int m_amode, m_lidx, m_curw, m_ref, m_lines, m_fw, m_fh;
  logic m_prev_de, m_mism, m_wm;

  function automatic int dim8(input int c, input int m);
    case (m)
      1: return c - c / 4;
      2: return c / 2;
      3: return c / 4;
      default: return c;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Drive one clock's worth of inputs and record what the outputs must become.
  task automatic cycle(input logic v, input logic h, input logic de,
                       input logic [23:0] rgb, input logic rst);
    logic [23:0] eo;
    logic fall;
    @(posedge clk_vid); #1;
    vsync_in = v; hsync_in = h; de_in = de; rgb_in = rgb;
    scanline_mode = mode_drv; reset = rst;
    if (rst) begin
      foreach (pix_q[i])
        if (pix_q[i].due > cyc) pix_q[i] = '{pix_q[i].due, 1'b0, 1'b0, 1'b0, 24'h0};
      m_amode = 0; m_lidx = 0; m_curw = 0; m_ref = 0; m_lines = 0;
      m_fw = 0; m_fh = 0; m_prev_de = 0; m_mism = 0; m_wm = 0;
      pix_q.push_back('{cyc + 2, 1'b0, 1'b0, 1'b0, 24'h0});
      st_q.push_back('{cyc + 1, 1'b0, 0, 0, 1'b0});
      return;
    end
    eo = rgb;
    if (de && (m_lidx % 2 == 1))
      for (int c = 0; c < 3; c++) eo[c*8 +: 8] = 8'(dim8(int'(rgb[c*8 +: 8]), m_amode));
    pix_q.push_back('{cyc + 2, v, h, de, eo});
    fall = m_prev_de && !de;
    if (fall) begin
      if (m_lines == 0) m_ref = m_curw;
      else if (m_curw != m_ref) m_mism = 1;
      m_lines = sat(m_lines + 1);
      m_lidx++;
      m_curw = 0;
    end else if (de) m_curw = sat(m_curw + 1);
    m_prev_de = de;
    if (v) begin
      m_fw = m_ref; m_fh = m_lines; m_wm = m_mism;
      m_ref = 0; m_lines = 0; m_mism = 0; m_lidx = 0; m_curw = 0;
      m_amode = int'(mode_drv);
    end
    st_q.push_back('{cyc + 1, v, m_fw, m_fh, m_wm});
  endtask

  // Monitor: every cycle is an output cycle; pop what is due and compare.
  always @(negedge clk_vid) begin
    pix_t e;
    st_t  s;
    while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
      void'(pix_q.pop_front()); n_chk++;
      $display("FAIL pix_stale @cyc %0d: entry not consumed, expected due earlier", cyc);
    end
    while (st_q.size() > 0 && st_q[0].due < cyc) begin
      void'(st_q.pop_front()); n_chk++;
      $display("FAIL st_stale @cyc %0d: entry not consumed, expected due earlier", cyc);
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      e = pix_q.pop_front();
      chk("vsync_out", int'(vsync_out), int'(e.v));
      chk("hsync_out", int'(hsync_out), int'(e.h));
      chk("de_out",    int'(de_out),    int'(e.de));
      chk("rgb_out",   int'(rgb_out),   int'(e.rgb));
    end
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      s = st_q.pop_front();
      chk("stats_valid",    int'(stats_valid),    int'(s.sv));
      chk("frame_width",    int'(frame_width),    s.fw);
      chk("frame_height",   int'(frame_height),   s.fh);
      chk("width_mismatch", int'(width_mismatch), int'(s.wm));
    end
  end

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  task automatic vs();
    cycle(1'b1, 1'b0, 1'b0, rnd24(), 1'b0);
  endtask

  // One line: hsync, blanking, w active pixels, then the de-fall/slot cycle
  // (optionally also the vsync), then a blanking cycle.
  task automatic line(input int w, input int col, input int slot, input logic vs_fall);
    cycle(1'b0, 1'b1, 1'b0, rnd24(), 1'b0);
    repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);
    for (int i = 0; i < w; i++)
      cycle(1'b0, 1'b0, 1'b1, (col < 0) ? rnd24() : 24'(col), 1'b0);
    cycle(vs_fall, 1'b0, 1'b0, (slot < 0) ? rnd24() : 24'(slot), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);
  endtask

  task automatic lines(input int n, input int w, input int bad_i, input int bad_w,
                       input int col, input logic coinc_end);
    for (int i = 0; i < n; i++)
      line((i == bad_i) ? bad_w : w, col, -1, coinc_end && (i == n - 1));
  endtask

  initial begin
    // reset and quiet period: no stats before the first vsync
    repeat (3) cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);

    // mode 2 dimming, fixed colour on even and odd lines
    mode_drv = 2; vs();
    lines(4, 8, -1, 0, 24'hFF8040, 1'b0);

    // mode change mid-frame has no effect until the next vsync
    mode_drv = 0; vs();
    lines(2, 6, -1, 0, 24'h808080, 1'b0);
    mode_drv = 3;
    lines(3, 6, -1, 0, 24'h808080, 1'b0);
    vs();
    lines(3, 6, -1, 0, 24'h808080, 1'b0);

    // statistics: many lines, and 256-wide lines
    mode_drv = 2'($urandom); vs();
    lines(224, 20, -1, 0, -1, 1'b0);
    vs();
    lines(16, 256, -1, 0, -1, 1'b0);

    // mismatch frame then a clean frame
    vs();
    lines(240, 24, 100, 23, -1, 1'b0);
    vs();
    lines(10, 24, -1, 0, -1, 1'b0);

    // slot word in mode 3, then vsync coinciding with the last de fall
    mode_drv = 3; vs();
    line(5, -1, 24'h028000, 1'b0);
    line(5, -1, 24'h028000, 1'b0);
    lines(4, 7, -1, 0, -1, 1'b1);
    lines(2, 9, -1, 0, -1, 1'b0);

    // width counter saturation
    vs();
    lines(2, 1030, -1, 0, -1, 1'b0);

    // zero-line frame
    vs(); vs();

    // vsync while de is high: partial line dropped
    vs();
    lines(2, 8, -1, 0, -1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, rnd24(), 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b1, rnd24(), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, rnd24(), 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, rnd24(), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);
    lines(2, 8, -1, 0, -1, 1'b0);
    vs();

    // reset mid-line, then quiet until the next vsync
    lines(2, 8, -1, 0, -1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, rnd24(), 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, rnd24(), 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, rnd24(), 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);
    mode_drv = 1; vs();
    lines(3, 8, -1, 0, -1, 1'b0);
    vs();

    // random frames
    for (int f = 0; f < 4; f++) begin
      int n, w;
      mode_drv = 2'($urandom);
      n = $urandom_range(1, 12);
      w = $urandom_range(1, 40);
      vs();
      lines(n, w, ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1,
            $urandom_range(1, 40), -1, 1'b0);
    end
    vs();

    repeat (4) cycle(1'b0, 1'b0, 1'b0, rnd24(), 1'b0);
    repeat (4) @(posedge clk_vid);
    @(negedge clk_vid);
    if (pix_q.size() != 0 || st_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", pix_q.size(), st_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
